// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: in-flight slot layout,
// the "operand not read" Tuse sentinel and the producer stage indices.
package hazard_pkg;

    localparam int HZ_AW  = 5;
    localparam int HZ_TW  = 2;
    localparam int SLOT_E = 1;
    localparam int SLOT_M = 2;
    localparam int SLOT_W = 3;

    localparam logic [HZ_TW-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic             v;
        logic             we;
        logic [HZ_AW-1:0] a1;
        logic [HZ_AW-1:0] a2;
        logic [HZ_AW-1:0] a3;
        logic [HZ_TW-1:0] tnew;
        logic             epcw;
    } slot_t;

    function automatic logic [HZ_TW-1:0] sat_dec(input logic [HZ_TW-1:0] t);
        return (t == '0) ? '0 : t - HZ_TW'(1);
    endfunction

    // $0 is hard-wired, so a writer to it never produces a value anyone waits on.
    function automatic logic slot_hit(input slot_t s, input logic [HZ_AW-1:0] a);
        return s.v && s.we && (s.a3 == a) && (a != '0);
    endfunction

endpackage

// File: rtl/hazard_md_counter.sv
// HI/LO busy countdown: loaded when a mult/div enters E, counts down to idle.
module hazard_md_counter
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic div,
    output logic md_busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] md_cnt_reg;

    // A flush does not touch the count: a started mult/div still completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_reg <= '0;
        end else if (load) begin
            md_cnt_reg <= div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_cnt_reg != '0) begin
            md_cnt_reg <= md_cnt_reg - CW'(1);
        end
    end

    assign md_busy = (md_cnt_reg != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// MIPS hazard unit tracking in-flight register writers E..W internally; produces
// the D stall, per-stage forward selects, HI/LO and eret/EPC interlocks.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE   = SLOT_W,
    parameter int AW       = HZ_AW,
    parameter int TW       = HZ_TW,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int EPC_ADDR = 14
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          D_valid,
    input  logic [AW-1:0] D_A1,
    input  logic [AW-1:0] D_A2,
    input  logic [TW-1:0] D_Tuse_rs,
    input  logic [TW-1:0] D_Tuse_rt,
    input  logic [AW-1:0] D_A3,
    input  logic          D_RegWrite,
    input  logic [TW-1:0] D_Tnew,
    input  logic          D_MD,
    input  logic          D_MDstart,
    input  logic          D_MDdiv,
    input  logic          D_eret,
    input  logic          D_mtc0,
    input  logic [4:0]    D_CP0Addr,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    D_fwd1,
    output logic [1:0]    D_fwd2,
    output logic [1:0]    E_fwd1,
    output logic [1:0]    E_fwd2,
    output logic [1:0]    M_fwd2,
    output logic          md_busy,
    output logic [31:0]   stall_cnt
);

    slot_t slot_reg  [1:NSTAGE];
    slot_t slot_next [1:NSTAGE];
    slot_t d_slot;

    logic [NSTAGE:1]  m_d1, m_d2, m_e1, m_e2, m_m2, epc_vec;
    logic [HZ_TW-1:0] tnew_vec [1:NSTAGE];

    int               p_d1, p_d2, p_e1, p_e2, p_m2;
    logic [HZ_TW-1:0] t_d1, t_d2, t_e1, t_e2, t_m2;
    logic             stall_rs, stall_rt, stall_md, stall_eret;
    logic [31:0]      stall_cnt_reg;

    always_comb begin
        d_slot      = '0;
        d_slot.v    = D_valid;
        d_slot.we   = D_RegWrite;
        d_slot.a1   = D_A1;
        d_slot.a2   = D_A2;
        d_slot.a3   = D_A3;
        d_slot.tnew = D_Tnew;
        d_slot.epcw = D_mtc0 && (D_CP0Addr == 5'(EPC_ADDR));
    end

    // Priority flush > stall > advance; deeper slots shift even while D is frozen.
    always_comb begin
        for (int s = 1; s <= NSTAGE; s++) slot_next[s] = '0;
        if (!flush) begin
            if (!stall) slot_next[1] = d_slot;
            for (int s = 2; s <= NSTAGE; s++) begin
                slot_next[s]      = slot_reg[s-1];
                slot_next[s].tnew = sat_dec(slot_reg[s-1].tnew);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 1; s <= NSTAGE; s++) slot_reg[s] <= '0;
        end else begin
            slot_reg <= slot_next;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= NSTAGE; gi++) begin : g_match
            assign m_d1[gi]     = slot_hit(slot_reg[gi], D_A1);
            assign m_d2[gi]     = slot_hit(slot_reg[gi], D_A2);
            assign m_e1[gi]     = slot_hit(slot_reg[gi], slot_reg[SLOT_E].a1);
            assign m_e2[gi]     = slot_hit(slot_reg[gi], slot_reg[SLOT_E].a2);
            assign m_m2[gi]     = slot_hit(slot_reg[gi], slot_reg[SLOT_M].a2);
            assign epc_vec[gi]  = slot_reg[gi].v && slot_reg[gi].epcw;
            assign tnew_vec[gi] = slot_reg[gi].tnew;
        end
    endgenerate

    // Scan deepest-first so the nearest producer overwrites (shadows) older ones.
    // D skips slot NSTAGE because the register file writes through.
    always_comb begin
        p_d1 = 0; p_d2 = 0; p_e1 = 0; p_e2 = 0; p_m2 = 0;
        t_d1 = '0; t_d2 = '0; t_e1 = '0; t_e2 = '0; t_m2 = '0;
        for (int s = NSTAGE; s >= 1; s--) begin
            if (s < NSTAGE && m_d1[s]) begin p_d1 = s; t_d1 = tnew_vec[s]; end
            if (s < NSTAGE && m_d2[s]) begin p_d2 = s; t_d2 = tnew_vec[s]; end
            if (s > SLOT_E && m_e1[s]) begin p_e1 = s; t_e1 = tnew_vec[s]; end
            if (s > SLOT_E && m_e2[s]) begin p_e2 = s; t_e2 = tnew_vec[s]; end
            if (s > SLOT_M && m_m2[s]) begin p_m2 = s; t_m2 = tnew_vec[s]; end
        end
    end

    assign D_fwd1 = (p_d1 != 0 && t_d1 == '0) ? 2'(p_d1) : 2'd0;
    assign D_fwd2 = (p_d2 != 0 && t_d2 == '0) ? 2'(p_d2) : 2'd0;
    assign E_fwd1 = (p_e1 != 0 && t_e1 == '0) ? 2'(p_e1) : 2'd0;
    assign E_fwd2 = (p_e2 != 0 && t_e2 == '0) ? 2'(p_e2) : 2'd0;
    assign M_fwd2 = (p_m2 != 0 && t_m2 == '0) ? 2'(p_m2) : 2'd0;

    assign stall_rs   = (D_Tuse_rs != TUSE_NONE) && (p_d1 != 0) && (t_d1 > D_Tuse_rs);
    assign stall_rt   = (D_Tuse_rt != TUSE_NONE) && (p_d2 != 0) && (t_d2 > D_Tuse_rt);
    assign stall_md   = D_MD && md_busy;
    assign stall_eret = D_eret && (|epc_vec[NSTAGE-1:1]);
    assign stall      = D_valid && (stall_rs || stall_rt || stall_md || stall_eret) && !flush;

    hazard_md_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (D_valid && D_MDstart && !stall && !flush),
        .div     (D_MDdiv),
        .md_busy (md_busy)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
        end else if (stall && stall_cnt_reg != 32'hFFFF_FFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle stimulus tables with
// expected outputs queued at drive time and compared on the falling edge.
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       valid;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [1:0] tu_rs;
        logic [1:0] tu_rt;
        logic [4:0] a3;
        logic       rw;
        logic [1:0] tnew;
        logic       md;
        logic       mdstart;
        logic       mddiv;
        logic       eret;
        logic       mtc0;
        logic [4:0] cp0;
        logic       flush;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] d1;
        logic [1:0] d2;
        logic [1:0] e1;
        logic [1:0] e2;
        logic [1:0] m2;
        logic       busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        D_valid, D_RegWrite, D_MD, D_MDstart, D_MDdiv, D_eret, D_mtc0, flush;
    logic [4:0]  D_A1, D_A2, D_A3, D_CP0Addr;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic        stall, md_busy;
    logic [1:0]  D_fwd1, D_fwd2, E_fwd1, E_fwd2, M_fwd2;
    logic [31:0] stall_cnt;

    int   n_chk = 0;
    int   n_bad = 0;
    int   exp_stalls = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .D_valid    (D_valid),
        .D_A1       (D_A1),
        .D_A2       (D_A2),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .D_A3       (D_A3),
        .D_RegWrite (D_RegWrite),
        .D_Tnew     (D_Tnew),
        .D_MD       (D_MD),
        .D_MDstart  (D_MDstart),
        .D_MDdiv    (D_MDdiv),
        .D_eret     (D_eret),
        .D_mtc0     (D_mtc0),
        .D_CP0Addr  (D_CP0Addr),
        .flush      (flush),
        .stall      (stall),
        .D_fwd1     (D_fwd1),
        .D_fwd2     (D_fwd2),
        .E_fwd1     (E_fwd1),
        .E_fwd2     (E_fwd2),
        .M_fwd2     (M_fwd2),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    function automatic stim_t alu(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                                  input logic [1:0] tr, input logic [1:0] tt,
                                  input logic [4:0] a3, input logic rw, input logic [1:0] tn);
        stim_t s;
        s       = '0;
        s.valid = v;
        s.a1    = a1;
        s.a2    = a2;
        s.tu_rs = tr;
        s.tu_rt = tt;
        s.a3    = a3;
        s.rw    = rw;
        s.tnew  = tn;
        return s;
    endfunction

    function automatic stim_t idle();
        return alu(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.stall = stall;
        o.d1    = D_fwd1;
        o.d2    = D_fwd2;
        o.e1    = E_fwd1;
        o.e2    = E_fwd2;
        o.m2    = M_fwd2;
        o.busy  = md_busy;
        return o;
    endfunction

    task automatic drive(input stim_t s);
        D_valid    = s.valid;
        D_A1       = s.a1;
        D_A2       = s.a2;
        D_Tuse_rs  = s.tu_rs;
        D_Tuse_rt  = s.tu_rt;
        D_A3       = s.a3;
        D_RegWrite = s.rw;
        D_Tnew     = s.tnew;
        D_MD       = s.md;
        D_MDstart  = s.mdstart;
        D_MDdiv    = s.mddiv;
        D_eret     = s.eret;
        D_mtc0     = s.mtc0;
        D_CP0Addr  = s.cp0;
        flush      = s.flush;
    endtask

    task automatic test_reset();
        exp_t o;
        stim_t s;
        reset_n = 1'b0;
        s = alu(1'b1, 5'd8, 5'd9, 2'd0, 2'd0, 5'd8, 1'b1, 2'd2);
        s.md = 1'b1;
        s.eret = 1'b1;
        drive(s);
        repeat (2) @(negedge clk);
        o = observe();
        n_chk++;
        if (o !== exp_t'('0)) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want %b", o, exp_t'('0));
        end else $display("tx reset outputs=%b", o);
        n_chk++;
        if (stall_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end else $display("tx reset stall_cnt=%0d", stall_cnt);
        drive(idle());
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // lw $8 then dependent add: one stall cycle, then E forwards from W.
    task automatic test_raw();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  e, o;
        for (int i = 0; i < 6; i++) begin st[i] = idle(); ex[i] = '0; end
        st[0] = alu(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd2);
        st[1] = alu(1'b1, 5'd8, 5'd11, 2'd1, 2'd1, 5'd10, 1'b1, 2'd1);
        st[2] = st[1];
        ex[1].stall = 1'b1;
        ex[3].e1    = 2'd3;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            if (ex[i].stall) exp_stalls++;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL raw c%0d: got %b want %b", i, o, e);
            end else $display("tx raw c%0d stall=%0b d=%0d/%0d e=%0d/%0d m=%0d busy=%0b",
                              i, o.stall, o.d1, o.d2, o.e1, o.e2, o.m2, o.busy);
        end
    endtask

    // lw $8 in M shadowed by addi $8 in E: beq forwards from E, no stall.
    task automatic test_shadow();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  e, o;
        for (int i = 0; i < 6; i++) begin st[i] = idle(); ex[i] = '0; end
        st[0] = alu(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd2);
        st[1] = alu(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd0);
        st[2] = alu(1'b1, 5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        ex[2].d1 = 2'd1;
        ex[3].e1 = 2'd2;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            if (ex[i].stall) exp_stalls++;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL shadow c%0d: got %b want %b", i, o, e);
            end else $display("tx shadow c%0d stall=%0b d=%0d/%0d e=%0d/%0d m=%0d busy=%0b",
                              i, o.stall, o.d1, o.d2, o.e1, o.e2, o.m2, o.busy);
        end
    endtask

    // mult then mfhi: exactly MULT_LAT stall cycles, busy drops with stall.
    task automatic test_md();
        stim_t st[10];
        exp_t  ex[10];
        exp_t  e, o;
        for (int i = 0; i < 10; i++) begin st[i] = idle(); ex[i] = '0; end
        st[0] = alu(1'b1, 5'd9, 5'd10, 2'd1, 2'd1, 5'd0, 1'b0, 2'd0);
        st[0].md = 1'b1;
        st[0].mdstart = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            st[i] = alu(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd11, 1'b1, 2'd1);
            st[i].md = 1'b1;
        end
        for (int i = 1; i <= 5; i++) begin ex[i].stall = 1'b1; ex[i].busy = 1'b1; end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            if (ex[i].stall) exp_stalls++;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL md c%0d: got %b want %b", i, o, e);
            end else $display("tx md c%0d stall=%0b busy=%0b", i, o.stall, o.busy);
        end
    endtask

    // mtc0 EPC then eret: stalls while the mtc0 sits in E and M.
    task automatic test_eret();
        stim_t st[7];
        exp_t  ex[7];
        exp_t  e, o;
        for (int i = 0; i < 7; i++) begin st[i] = idle(); ex[i] = '0; end
        st[0] = alu(1'b1, 5'd0, 5'd12, 2'd3, 2'd1, 5'd0, 1'b0, 2'd0);
        st[0].mtc0 = 1'b1;
        st[0].cp0  = 5'd14;
        for (int i = 1; i <= 3; i++) begin
            st[i] = alu(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
            st[i].eret = 1'b1;
        end
        ex[1].stall = 1'b1;
        ex[2].stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            if (ex[i].stall) exp_stalls++;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL eret c%0d: got %b want %b", i, o, e);
            end else $display("tx eret c%0d stall=%0b", i, o.stall);
        end
    endtask

    // Writers to $0 or with RegWrite=0 never create hazards or forwards.
    task automatic test_zero_nowrite();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  e, o;
        for (int i = 0; i < 6; i++) begin st[i] = idle(); ex[i] = '0; end
        st[0] = alu(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 5'd0, 1'b1, 2'd2);
        st[1] = alu(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd8, 1'b0, 2'd2);
        st[2] = alu(1'b1, 5'd8, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            if (ex[i].stall) exp_stalls++;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL zero_nowrite c%0d: got %b want %b", i, o, e);
            end else $display("tx zero_nowrite c%0d stall=%0b d=%0d e=%0d", i, o.stall, o.d1, o.e1);
        end
    endtask

    // Flush masks a pending stall and empties every slot for the next cycle.
    task automatic test_flush();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  e, o;
        for (int i = 0; i < 6; i++) begin st[i] = idle(); ex[i] = '0; end
        st[0] = alu(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd3);
        st[1] = alu(1'b1, 5'd8, 5'd0, 2'd0, 2'd3, 5'd10, 1'b1, 2'd1);
        st[1].flush = 1'b1;
        st[2] = alu(1'b1, 5'd8, 5'd0, 2'd0, 2'd3, 5'd10, 1'b1, 2'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            if (ex[i].stall) exp_stalls++;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL flush c%0d: got %b want %b", i, o, e);
            end else $display("tx flush c%0d stall=%0b d=%0d", i, o.stall, o.d1);
        end
    endtask

    // Stall counter total, then an asynchronous reset in the middle of a div.
    task automatic test_reset_mid_div();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e, o;
        for (int i = 0; i < 3; i++) begin st[i] = idle(); ex[i] = '0; end
        st[0] = alu(1'b1, 5'd9, 5'd10, 2'd1, 2'd1, 5'd0, 1'b0, 2'd0);
        st[0].md = 1'b1;
        st[0].mdstart = 1'b1;
        st[0].mddiv = 1'b1;
        ex[1].busy = 1'b1;
        ex[2].busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL div c%0d: got %b want %b", i, o, e);
            end else $display("tx div c%0d busy=%0b", i, o.busy);
        end
        n_chk++;
        if (stall_cnt !== 32'(exp_stalls)) begin
            n_bad++;
            $display("FAIL stall_cnt_total: got %0d want %0d", stall_cnt, exp_stalls);
        end else $display("tx stall_cnt total=%0d", stall_cnt);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        o = observe();
        n_chk++;
        if (o !== exp_t'('0)) begin
            n_bad++;
            $display("FAIL async_reset_outputs: got %b want %b", o, exp_t'('0));
        end else $display("tx async reset outputs=%b", o);
        n_chk++;
        if (stall_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset_stall_cnt: got %0d want 0", stall_cnt);
        end else $display("tx async reset stall_cnt=%0d", stall_cnt);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(idle());
            exp_q.push_back(exp_t'('0));
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL post_reset c%0d: got %b want %b", i, o, e);
            end else $display("tx post_reset c%0d busy=%0b", i, o.busy);
        end
    endtask

    initial begin
        drive(idle());
        test_reset();
        test_raw();
        test_shadow();
        test_md();
        test_eret();
        test_zero_nowrite();
        test_flush();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
